// File: rtl/msdf_pkg.sv
// Shared definitions for the MSDF (most-significant-digit-first) datapath blocks.
// Contents:
//   otf_state_t      - on-the-fly converter control states
//   digit_width()    - bits in a two's-complement signed digit for a given radix
//   is_illegal_digit - flags the one code outside -(r-1)..+(r-1), i.e. -r
package msdf_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } otf_state_t;

  function automatic int unsigned digit_width(input int unsigned radix);
    return 32'($clog2(radix)) + 32'd1;
  endfunction

  // The code -r is the only pattern with the sign bit set and all other bits
  // clear; the caller passes the digit zero-extended to 32 bits.
  function automatic logic is_illegal_digit(input logic [31:0] code, input int unsigned dw);
    return code == (32'd1 << (dw - 32'd1));
  endfunction

endpackage

// File: rtl/otf_digit_step.sv
// One on-the-fly conversion step on the Q/QM register pair.
// Q holds the value so far, QM holds Q - 1, so a negative digit never needs a
// borrow to propagate: it just selects QM instead of Q.
// Ports:
//   q, qm           - current Q / QM (W bits)
//   digit           - signed digit, DW bits, two's complement
//   q_next, qm_next - updated pair after shifting in the digit
//   illegal         - digit is the reserved code -RADIX (treated as 0)
module otf_digit_step
  import msdf_pkg::*;
#(
  parameter int unsigned RADIX = 2,
  parameter int unsigned W     = 33,
  localparam int unsigned DW   = digit_width(RADIX)
) (
  input  logic [W-1:0]  q,
  input  logic [W-1:0]  qm,
  input  logic [DW-1:0] digit,
  output logic [W-1:0]  q_next,
  output logic [W-1:0]  qm_next,
  output logic          illegal
);

  localparam int unsigned K = DW - 1;

  logic [W-1:0] d_ext;
  logic [W-1:0] q_sh;
  logic [W-1:0] qm_sh;
  logic [W-1:0] qm_up;
  logic [W-1:0] q_pos;
  logic [W-1:0] q_neg;

  assign illegal = is_illegal_digit(32'(digit), DW);
  assign d_ext   = illegal ? '0 : W'($signed(digit));
  assign q_sh    = q << K;
  assign qm_sh   = qm << K;
  assign qm_up   = qm_sh + W'(RADIX);  // QM*r + r == Q*r
  assign q_pos   = q_sh + d_ext;
  assign q_neg   = qm_up + d_ext;

  always_comb begin
    q_next  = q_sh;
    qm_next = qm_up - W'(1);
    if (!illegal && digit != '0) begin
      if (digit[DW-1]) begin
        q_next  = q_neg;
        qm_next = q_neg - W'(1);
      end else begin
        q_next  = q_pos;
        qm_next = q_pos - W'(1);
      end
    end
  end

endmodule

// File: rtl/msdf_otf_converter.sv
// Digit-serial on-the-fly converter: assembles DIGITS signed digits (MSD first)
// into a W-bit two's-complement word, ready one cycle after the last digit.
// Ports:
//   clock, resetn          - clock, asynchronous active-low reset
//   clear                  - synchronous abort of partial and held results
//   in_valid/in_first      - digit strobe / first-digit marker
//   in_digit               - signed digit, DW bits
//   in_ready               - digit accepted when in_valid && in_ready
//   out_valid/out_ready    - result handshake
//   out_data, out_err      - registered result and illegal-digit flag
module msdf_otf_converter
  import msdf_pkg::*;
#(
  parameter int unsigned RADIX  = 2,
  parameter int unsigned DIGITS = 16,
  localparam int unsigned DW    = digit_width(RADIX),
  localparam int unsigned K     = DW - 1,
  localparam int unsigned W     = K * DIGITS + 1,
  localparam int unsigned CW    = $clog2(DIGITS + 1)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          clear,
  input  logic          in_valid,
  input  logic          in_first,
  input  logic [DW-1:0] in_digit,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_err
);

  otf_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  qm_q, qm_d;
  logic          err_q, err_d;
  logic [W-1:0]  data_q, data_d;
  logic          err_out_q, err_out_d;

  logic          accept;
  logic          start;
  logic          take;
  logic [W-1:0]  base_q;
  logic [W-1:0]  base_qm;
  logic [W-1:0]  step_q;
  logic [W-1:0]  step_qm;
  logic          step_illegal;
  logic          err_acc;
  logic [CW-1:0] cnt_inc;

  assign in_ready  = (state_q != StDone) || out_ready;
  assign out_valid = (state_q == StDone);
  assign out_data  = data_q;
  assign out_err   = err_out_q;

  assign accept  = in_valid && in_ready;
  assign start   = accept && in_first;
  // Outside ACCUM only a first digit is meaningful; anything else is dropped.
  assign take    = (state_q == StAccum) ? accept : start;
  assign base_q  = start ? '0 : q_q;
  assign base_qm = start ? '1 : qm_q;
  assign err_acc = (start ? 1'b0 : err_q) | step_illegal;
  assign cnt_inc = start ? CW'(1) : cnt_q + CW'(1);

  otf_digit_step #(
    .RADIX(RADIX),
    .W    (W)
  ) u_step (
    .q      (base_q),
    .qm     (base_qm),
    .digit  (in_digit),
    .q_next (step_q),
    .qm_next(step_qm),
    .illegal(step_illegal)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    qm_d      = qm_q;
    err_d     = err_q;
    data_d    = data_q;
    err_out_d = err_out_q;

    if (state_q == StDone && out_ready) begin
      state_d = StIdle;
    end

    if (take) begin
      q_d   = step_q;
      qm_d  = step_qm;
      err_d = err_acc;
      cnt_d = cnt_inc;
      if (cnt_inc == CW'(DIGITS)) begin
        state_d   = StDone;
        data_d    = step_q;
        err_out_d = err_acc;
      end else begin
        state_d = StAccum;
      end
    end

    if (clear) begin
      state_d   = StIdle;
      cnt_d     = '0;
      q_d       = '0;
      qm_d      = '1;
      err_d     = 1'b0;
      err_out_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      q_q       <= '0;
      qm_q      <= '1;
      err_q     <= 1'b0;
      data_q    <= '0;
      err_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      qm_q      <= qm_d;
      err_q     <= err_d;
      data_q    <= data_d;
      err_out_q <= err_out_d;
    end
  end

endmodule

// File: tb/tb_msdf_otf_converter.sv
// Bench for msdf_otf_converter: two instances (radix 2 x 4 digits, radix 4 x 2
// digits), a driver that pushes reference results into per-instance queues and
// a monitor that pops them on every output handshake.
module tb_msdf_otf_converter;

  typedef struct packed {
    logic [4:0] data;
    logic       err;
  } exp_t;

  logic       clock = 1'b0;
  logic       resetn;
  logic       clear;
  logic       in_valid [2];
  logic       in_first [2];
  logic       in_ready [2];
  logic       out_valid[2];
  logic       out_ready[2];
  logic       out_err  [2];
  logic [4:0] out_data [2];
  logic [1:0] in_digit_a;
  logic [2:0] in_digit_b;
  int         mode[2];  // 0: random out_ready, 1: held low, 2: held high
  int         n_checks = 0;
  int         n_fail = 0;
  exp_t       exp_q0[$];
  exp_t       exp_q1[$];

  always #5 clock = ~clock;

  msdf_otf_converter #(.RADIX(2), .DIGITS(4)) dut_a (
    .clock    (clock),
    .resetn   (resetn),
    .clear    (clear),
    .in_valid (in_valid[0]),
    .in_first (in_first[0]),
    .in_digit (in_digit_a),
    .in_ready (in_ready[0]),
    .out_valid(out_valid[0]),
    .out_ready(out_ready[0]),
    .out_data (out_data[0]),
    .out_err  (out_err[0])
  );

  msdf_otf_converter #(.RADIX(4), .DIGITS(2)) dut_b (
    .clock    (clock),
    .resetn   (resetn),
    .clear    (clear),
    .in_valid (in_valid[1]),
    .in_first (in_first[1]),
    .in_digit (in_digit_b),
    .in_ready (in_ready[1]),
    .out_valid(out_valid[1]),
    .out_ready(out_ready[1]),
    .out_data (out_data[1]),
    .out_err  (out_err[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: value = sum d_i * r^(DIGITS-i) with the code -r counted as 0.
  function automatic exp_t model(input int u, input int digs[$]);
    int    r;
    longint v;
    exp_t  e;
    r = (u == 0) ? 2 : 4;
    v = 0;
    e.err = 1'b0;
    foreach (digs[i]) begin
      if (digs[i] == -r) begin
        e.err = 1'b1;
        v = v * r;
      end else begin
        v = v * r + longint'(digs[i]);
      end
    end
    e.data = 5'(v);
    return e;
  endfunction

  initial begin
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      for (int u = 0; u < 2; u++) begin
        out_ready[u] = (mode[u] == 0) ? 1'($urandom_range(0, 1)) : (mode[u] == 2);
      end
    end
  end

  always @(negedge clock) begin
    for (int u = 0; u < 2; u++) begin
      if (resetn === 1'b1 && out_valid[u] && out_ready[u]) begin
        exp_t e;
        if ((u == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0)) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output dut%0d: got data %0h, no result expected", u,
                   out_data[u]);
        end else begin
          e = (u == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          chk($sformatf("out_data dut%0d", u), 32'(out_data[u]), 32'(e.data));
          chk($sformatf("out_err dut%0d", u), 32'(out_err[u]), 32'(e.err));
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that took the digit.
  task automatic send_digit(input int u, input int d, input logic first, output int stalls,
                            output logic ok);
    logic [2:0] c;
    c = 3'(d);
    if (u == 0) in_digit_a = c[1:0];
    else in_digit_b = c;
    in_valid[u] = 1'b1;
    in_first[u] = first;
    stalls = 0;
    ok = 1'b0;
    while (!ok && stalls < 100) begin
      @(negedge clock);
      if (in_ready[u]) ok = 1'b1;
      else stalls++;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout dut%0d: got no acceptance, expected one within 100 cycles", u);
    end
    @(posedge clock);
    #1;
    in_valid[u] = 1'b0;
    in_first[u] = 1'b0;
  endtask

  task automatic send_num(input int u, input int digs[$], output int stalls_total);
    int   s;
    logic ok;
    logic all_ok;
    exp_t e;
    stalls_total = 0;
    all_ok = 1'b1;
    foreach (digs[i]) begin
      send_digit(u, digs[i], i == 0, s, ok);
      stalls_total += s;
      all_ok &= ok;
    end
    if (all_ok) begin
      e = model(u, digs);
      if (u == 0) exp_q0.push_back(e);
      else exp_q1.push_back(e);
      chk($sformatf("latency_valid dut%0d", u), 32'(out_valid[u]), 32'd1);
    end
  endtask

  function automatic int rand_digit(input int u);
    int r;
    r = (u == 0) ? 2 : 4;
    if ($urandom_range(0, 7) == 0) return -r;
    return int'($urandom_range(0, 2 * r - 2)) - (r - 1);
  endfunction

  initial begin
    int   dq[$];
    int   s;
    int   st;
    logic ok;
    exp_t e;
    resetn = 1'b0;
    clear = 1'b0;
    mode[0] = 2;
    mode[1] = 2;
    for (int u = 0; u < 2; u++) begin
      in_valid[u] = 1'b0;
      in_first[u] = 1'b0;
    end
    in_digit_a = '0;
    in_digit_b = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("reset out_valid dut%0d", u), 32'(out_valid[u]), 32'd0);
      chk($sformatf("reset out_data dut%0d", u), 32'(out_data[u]), 32'd0);
      chk($sformatf("reset out_err dut%0d", u), 32'(out_err[u]), 32'd0);
      chk($sformatf("reset in_ready dut%0d", u), 32'(in_ready[u]), 32'd1);
    end
    resetn = 1'b1;
    @(posedge clock);
    #1;

    // Radix 2, four digits: 7, -15, 1, then an illegal leading digit.
    dq = {1, 0, -1, 1};    send_num(0, dq, s);
    dq = {-1, -1, -1, -1}; send_num(0, dq, s);
    dq = {1, -1, -1, -1};  send_num(0, dq, s);
    dq = {-2, 1, 0, -1};   send_num(0, dq, s);

    // Backpressure: result held for 5 cycles while the next first digit waits.
    mode[0] = 1;
    dq = {1, 1, 0, 1};
    send_num(0, dq, s);
    e = model(0, dq);
    in_digit_a = 2'b01;
    in_valid[0] = 1'b1;
    in_first[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("bp out_valid", 32'(out_valid[0]), 32'd1);
      chk("bp out_data", 32'(out_data[0]), 32'(e.data));
      chk("bp in_ready", 32'(in_ready[0]), 32'd0);
    end
    mode[0] = 2;
    @(posedge clock);
    #1;
    st = 0;
    dq = {1, 0, 0, -1}; send_num(0, dq, s); st += s;
    dq = {0, 1, -1, 0}; send_num(0, dq, s); st += s;
    dq = {-1, 1, 1, 1}; send_num(0, dq, s); st += s;
    chk("no_bubble stalls", 32'(st), 32'd0);

    // Restart after two digits, then stray digits while idle.
    send_digit(0, 1, 1'b1, s, ok);
    send_digit(0, -1, 1'b0, s, ok);
    dq = {-1, 0, 1, 1}; send_num(0, dq, s);
    repeat (3) send_digit(0, 1, 1'b0, s, ok);

    // Clear during accumulation: trailing digits must be dropped.
    send_digit(0, 1, 1'b1, s, ok);
    send_digit(0, 1, 1'b0, s, ok);
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    chk("clear out_valid", 32'(out_valid[0]), 32'd0);
    repeat (2) send_digit(0, -1, 1'b0, s, ok);

    // Clear while a result is held.
    mode[0] = 1;
    dq = {0, 0, 0, 1}; send_num(0, dq, s);
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    void'(exp_q0.pop_back());
    chk("clear_done out_valid", 32'(out_valid[0]), 32'd0);
    chk("clear_done out_err", 32'(out_err[0]), 32'd0);

    // Asynchronous reset while a result is held.
    dq = {-2, 1, 1, 1}; send_num(0, dq, s);
    void'(exp_q0.pop_back());
    #2;
    resetn = 1'b0;
    #1;
    chk("async_reset out_valid", 32'(out_valid[0]), 32'd0);
    chk("async_reset out_data", 32'(out_data[0]), 32'd0);
    chk("async_reset out_err", 32'(out_err[0]), 32'd0);
    chk("async_reset in_ready", 32'(in_ready[0]), 32'd1);
    @(negedge clock);
    resetn = 1'b1;
    mode[0] = 2;
    @(posedge clock);
    #1;

    for (int n = 0; n < 60; n++) begin
      mode[0] = ($urandom_range(0, 2) == 0) ? 2 : 0;
      if ($urandom_range(0, 5) == 0) send_digit(0, rand_digit(0), 1'b0, s, ok);
      if ($urandom_range(0, 5) == 0) begin
        send_digit(0, rand_digit(0), 1'b1, s, ok);
        send_digit(0, rand_digit(0), 1'b0, s, ok);
      end
      dq = {};
      repeat (4) dq.push_back(rand_digit(0));
      send_num(0, dq, s);
    end

    // Radix 4, two digits: 9, illegal codes in either position, -15.
    dq = {3, -3};  send_num(1, dq, s);
    dq = {-4, 3};  send_num(1, dq, s);
    dq = {2, -4};  send_num(1, dq, s);
    dq = {-3, -3}; send_num(1, dq, s);
    for (int n = 0; n < 60; n++) begin
      mode[1] = ($urandom_range(0, 2) == 0) ? 2 : 0;
      if ($urandom_range(0, 5) == 0) send_digit(1, rand_digit(1), 1'b0, s, ok);
      dq = {};
      repeat (2) dq.push_back(rand_digit(1));
      send_num(1, dq, s);
    end

    mode[0] = 2;
    mode[1] = 2;
    for (int i = 0; i < 50 && (exp_q0.size() + exp_q1.size()) != 0; i++) @(posedge clock);
    @(negedge clock);
    chk("drain dut0", 32'(exp_q0.size()), 32'd0);
    chk("drain dut1", 32'(exp_q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
